reaction_game_core: RTL and testbench

Parametrised reaction-time game engine: runs a configurable number of rounds, each with an LFSR-randomised hold-off, a timed "go" window, and per-round scoring. Tracks a best score across games. Sits between the button/switch front end and the per-screen OLED renderers, driving `state` and score outputs that the display mux consumes. Replaces the derived slow clocks with a single-clock tick-enable design.

---
 rtl/game_pkg.sv | 46 ++++
 rtl/btn_edge.sv | 28 ++
 rtl/reaction_game_core.sv | 218 +++++++++++++++++++++
 tb/tb_reaction_game_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings and helpers for the reaction game: FSM states, round results, LFSR taps.
// Pure declarations; no timing or flow control of its own.
package game_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_WAIT      = 3'd2;
    localparam logic [2:0] ST_GO        = 3'd3;
    localparam logic [2:0] ST_RESULT    = 3'd4;
    localparam logic [2:0] ST_FINISH    = 3'd5;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_HIT   = 2'd1,
        RES_EARLY = 2'd2,
        RES_MISS  = 2'd3
    } result_e;

    // Maximal-length Fibonacci tap masks; bit i set means register bit i feeds the XOR.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h00B8;
        endcase
        return taps;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for a raw button level.
// Latency: 3 cycles from button to one-cycle rise pulse; no backpressure.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            rise  <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/reaction_game_core.sv
// Reaction-time game engine: countdown, randomised hold-off, timed go window, per-round scoring.
// Button edges act 3 cycles after the press; counters advance on the divided tick; no backpressure.
module reaction_game_core
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 1_000_000,
    parameter int ROUNDS      = 4,
    parameter int CNT_W       = 9,
    parameter int MIN_DELAY   = 100,
    parameter int TIMEOUT     = 300,
    parameter int COUNTDOWN   = 500,
    parameter int RESULT_HOLD = 100
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            start,
    input  logic                            react,
    input  logic [CNT_W-1:0]                seed_in,
    output logic [2:0]                      state,
    output logic                            go,
    output logic [clog2(ROUNDS):0]          round_idx,
    output logic [1:0]                      result,
    output logic [CNT_W-1:0]                last_score,
    output logic [CNT_W+clog2(ROUNDS):0]    total_score,
    output logic [CNT_W+clog2(ROUNDS):0]    best_score,
    output logic [CNT_W+3:0]                countdown_left,
    output logic                            done
);

    localparam int RW = clog2(ROUNDS) + 1;
    localparam int TW = CNT_W + RW;
    localparam int HW = CNT_W + 4;
    localparam int DW = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;

    localparam logic [15:0]      TAPS_ALL   = lfsr_taps(CNT_W);
    localparam logic [CNT_W-1:0] TAPS       = TAPS_ALL[CNT_W-1:0];
    localparam logic [RW-1:0]    LAST_ROUND = RW'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] MIN_D      = CNT_W'(MIN_DELAY);
    localparam logic [CNT_W-1:0] TMO        = CNT_W'(TIMEOUT);
    localparam logic [HW-1:0]    CD_LOAD    = HW'(COUNTDOWN);
    localparam logic [HW-1:0]    HOLD_LOAD  = HW'(RESULT_HOLD);
    localparam logic [DW-1:0]    DIV_LAST   = DW'(TICK_DIV - 1);

    logic             start_rise;
    logic             react_rise;
    logic [DW-1:0]    div_cnt;
    logic             tick;
    logic [CNT_W-1:0] free_cnt;
    logic [CNT_W-1:0] lfsr;
    logic [CNT_W-1:0] lfsr_next;
    logic [CNT_W-1:0] seed_mix;
    logic [CNT_W-1:0] delay_load;
    logic [CNT_W-1:0] delay_cnt;
    logic [CNT_W-1:0] go_cnt;
    logic [HW-1:0]    hold_cnt;
    logic             new_game;

    btn_edge u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (start),
        .rise (start_rise)
    );

    btn_edge u_react_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (react),
        .rise (react_rise)
    );

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Free-running count only perturbs the seed so repeated identical seed_in values still differ.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_cnt <= '0;
        end else begin
            free_cnt <= free_cnt + CNT_W'(1);
        end
    end

    assign seed_mix   = seed_in ^ free_cnt;
    assign lfsr_next  = {lfsr[CNT_W-2:0], ^(lfsr & TAPS)};
    assign delay_load = (lfsr < MIN_D) ? (lfsr + MIN_D) : lfsr;
    assign new_game   = start_rise && enable && ((state == ST_IDLE) || (state == ST_FINISH));

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= CNT_W'(1);
        end else if (new_game) begin
            lfsr <= (seed_mix == '0) ? CNT_W'(1) : seed_mix;
        end else if (tick) begin
            lfsr <= lfsr_next;
        end
    end

    assign go = (state == ST_GO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            round_idx      <= '0;
            result         <= RES_NONE;
            last_score     <= '0;
            total_score    <= '0;
            best_score     <= '0;
            countdown_left <= '0;
            delay_cnt      <= '0;
            go_cnt         <= '0;
            hold_cnt       <= '0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!enable) begin
                state          <= ST_IDLE;
                round_idx      <= '0;
                result         <= RES_NONE;
                last_score     <= '0;
                total_score    <= '0;
                countdown_left <= '0;
                delay_cnt      <= '0;
                go_cnt         <= '0;
                hold_cnt       <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_FINISH: begin
                        if (start_rise) begin
                            total_score    <= '0;
                            round_idx      <= '0;
                            result         <= RES_NONE;
                            countdown_left <= CD_LOAD;
                            state          <= ST_COUNTDOWN;
                        end
                    end
                    ST_COUNTDOWN: begin
                        if (tick) begin
                            if (countdown_left <= HW'(1)) begin
                                countdown_left <= '0;
                                delay_cnt      <= delay_load;
                                state          <= ST_WAIT;
                            end else begin
                                countdown_left <= countdown_left - HW'(1);
                            end
                        end
                    end
                    ST_WAIT: begin
                        // A press on the very tick the hold-off expires still counts as early.
                        if (react_rise) begin
                            result     <= RES_EARLY;
                            last_score <= '0;
                            hold_cnt   <= HOLD_LOAD;
                            state      <= ST_RESULT;
                        end else if (tick) begin
                            if (delay_cnt <= CNT_W'(1)) begin
                                delay_cnt <= '0;
                                go_cnt    <= TMO;
                                state     <= ST_GO;
                            end else begin
                                delay_cnt <= delay_cnt - CNT_W'(1);
                            end
                        end
                    end
                    ST_GO: begin
                        if (react_rise) begin
                            result      <= RES_HIT;
                            last_score  <= go_cnt;
                            total_score <= total_score + TW'(go_cnt);
                            hold_cnt    <= HOLD_LOAD;
                            state       <= ST_RESULT;
                        end else if (tick) begin
                            if (go_cnt <= CNT_W'(1)) begin
                                go_cnt     <= '0;
                                result     <= RES_MISS;
                                last_score <= '0;
                                hold_cnt   <= HOLD_LOAD;
                                state      <= ST_RESULT;
                            end else begin
                                go_cnt <= go_cnt - CNT_W'(1);
                            end
                        end
                    end
                    ST_RESULT: begin
                        if (tick) begin
                            if (hold_cnt <= HW'(1)) begin
                                hold_cnt <= '0;
                                if (round_idx == LAST_ROUND) begin
                                    done  <= 1'b1;
                                    state <= ST_FINISH;
                                    if (total_score > best_score) begin
                                        best_score <= total_score;
                                    end
                                end else begin
                                    round_idx <= round_idx + RW'(1);
                                    delay_cnt <= delay_load;
                                    state     <= ST_WAIT;
                                end
                            end else begin
                                hold_cnt <= hold_cnt - HW'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reaction_game_core.sv
// Directed bench for reaction_game_core with a 4-cycle tick and two-round games.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_reaction_game_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        start;
    logic        react;
    logic [8:0]  seed_in;
    logic [2:0]  state;
    logic        go;
    logic [1:0]  round_idx;
    logic [1:0]  result;
    logic [8:0]  last_score;
    logic [10:0] total_score;
    logic [10:0] best_score;
    logic [12:0] countdown_left;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Cycle count since reset; the engine mixes the same count into its seed.
    logic [8:0] fc;
    logic [8:0] seed_target;

    reaction_game_core #(
        .TICK_DIV    (4),
        .ROUNDS      (2),
        .CNT_W       (9),
        .MIN_DELAY   (5),
        .TIMEOUT     (10),
        .COUNTDOWN   (3),
        .RESULT_HOLD (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .start          (start),
        .react          (react),
        .seed_in        (seed_in),
        .state          (state),
        .go             (go),
        .round_idx      (round_idx),
        .result         (result),
        .last_score     (last_score),
        .total_score    (total_score),
        .best_score     (best_score),
        .countdown_left (countdown_left),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) fc <= 9'd0;
        else     fc <= fc + 9'd1;
    end

    always @(negedge clk) seed_in = seed_target ^ fc;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (state !== s && n < budget) begin
            step;
            n++;
        end
        if (state !== s) begin
            checks++;
            errors++;
            $display("FAIL wait_state timeout: state=%0d required=%0d", state, s);
        end
    endtask

    // Raise start where the consuming edge is not a tick edge; returns in the first COUNTDOWN cycle.
    task automatic start_game(input logic [8:0] tgt);
        seed_target = tgt;
        for (int i = 0; i < 4 && fc[1:0] != 2'd1; i++) step;
        start = 1'b1;
        repeat (4) step;
        start = 1'b0;
    endtask

    // Called in the first GO cycle; the press lands while go_cnt == TIMEOUT - ticks.
    task automatic react_after(input int ticks);
        int n;
        repeat (4 * ticks) step;
        react = 1'b1;
        wait_state(3'd4, 10, n);
        react = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; start = 1'b0; react = 1'b0; seed_target = 9'd0;
        repeat (3) step;
        if (state !== 3'd0)           begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++;
        if (go !== 1'b0)              begin errors++; $display("FAIL reset_go got=%0d exp=0", go); end
        checks++;
        if (round_idx !== 2'd0)       begin errors++; $display("FAIL reset_round got=%0d exp=0", round_idx); end
        checks++;
        if (result !== 2'd0)          begin errors++; $display("FAIL reset_result got=%0d exp=0", result); end
        checks++;
        if (total_score !== 11'd0)    begin errors++; $display("FAIL reset_total got=%0d exp=0", total_score); end
        checks++;
        if (best_score !== 11'd0)     begin errors++; $display("FAIL reset_best got=%0d exp=0", best_score); end
        checks++;
        if (countdown_left !== 13'd0) begin errors++; $display("FAIL reset_countdown got=%0d exp=0", countdown_left); end
        checks++;
        if (done !== 1'b0)            begin errors++; $display("FAIL reset_done got=%0d exp=0", done); end
        checks++;
        rst = 1'b0;
        enable = 1'b1;
        step;
    endtask

    task automatic test_hit_game;
        int n;
        start_game(9'h0A5);
        if (state !== 3'd1 || countdown_left !== 13'd3) begin
            errors++; $display("FAIL countdown_entry state=%0d cd=%0d exp 1/3", state, countdown_left);
        end
        checks++;
        wait_state(3'd2, 100, n);
        if (n !== 11) begin errors++; $display("FAIL countdown_len got=%0d exp=11", n); end
        checks++;
        // seed 0x0A5 -> 0x14A -> 0x095 = 149 ticks of hold-off
        wait_state(3'd3, 2100, n);
        if (n !== 596) begin errors++; $display("FAIL wait_len_seed_a5 got=%0d exp=596", n); end
        checks++;
        react_after(3);
        if (result !== 2'd1 || last_score !== 9'd7 || total_score !== 11'd7) begin
            errors++; $display("FAIL hit1 result=%0d last=%0d total=%0d exp 1/7/7", result, last_score, total_score);
        end
        checks++;
        wait_state(3'd2, 20, n);
        if (n !== 8 || round_idx !== 2'd1) begin
            errors++; $display("FAIL result_hold len=%0d round=%0d exp 8/1", n, round_idx);
        end
        checks++;
        wait_state(3'd3, 2100, n);
        react_after(3);
        if (result !== 2'd1 || last_score !== 9'd7 || total_score !== 11'd14) begin
            errors++; $display("FAIL hit2 result=%0d last=%0d total=%0d exp 1/7/14", result, last_score, total_score);
        end
        checks++;
        wait_state(3'd5, 20, n);
        if (done !== 1'b1) begin errors++; $display("FAIL done_pulse got=%0d exp=1", done); end
        checks++;
        if (best_score !== 11'd14) begin errors++; $display("FAIL best_game1 got=%0d exp=14", best_score); end
        checks++;
        step;
        if (done !== 1'b0) begin errors++; $display("FAIL done_width got=%0d exp=0", done); end
        checks++;
    endtask

    task automatic test_seed_low;
        int n;
        // seed 0x180 -> 0x101 -> 0x003, below MIN_DELAY so hold-off = 8 ticks
        start_game(9'h180);
        wait_state(3'd2, 100, n);
        wait_state(3'd3, 2100, n);
        if (n !== 32) begin errors++; $display("FAIL wait_len_low_lfsr got=%0d exp=32", n); end
        checks++;
        react_after(5);
        if (result !== 2'd1 || last_score !== 9'd5 || total_score !== 11'd5) begin
            errors++; $display("FAIL hit5 result=%0d last=%0d total=%0d exp 1/5/5", result, last_score, total_score);
        end
        checks++;
    endtask

    task automatic test_miss;
        int n;
        wait_state(3'd2, 20, n);
        wait_state(3'd3, 2100, n);
        wait_state(3'd4, 60, n);
        if (n !== 40) begin errors++; $display("FAIL go_window_len got=%0d exp=40", n); end
        checks++;
        if (result !== 2'd3 || last_score !== 9'd0 || total_score !== 11'd5) begin
            errors++; $display("FAIL miss result=%0d last=%0d total=%0d exp 3/0/5", result, last_score, total_score);
        end
        checks++;
        wait_state(3'd5, 20, n);
        if (best_score !== 11'd14 || done !== 1'b1) begin
            errors++; $display("FAIL best_kept_low best=%0d done=%0d exp 14/1", best_score, done);
        end
        checks++;
    endtask

    task automatic test_early;
        int  n;
        logic saw_go;
        start_game(9'h0A5);
        wait_state(3'd2, 100, n);
        react = 1'b1;
        n = 0;
        saw_go = 1'b0;
        while (state !== 3'd4 && n < 40) begin
            step;
            n++;
            if (go === 1'b1) saw_go = 1'b1;
        end
        react = 1'b0;
        if (n !== 4) begin errors++; $display("FAIL early_latency got=%0d exp=4", n); end
        checks++;
        if (result !== 2'd2 || last_score !== 9'd0) begin
            errors++; $display("FAIL early result=%0d last=%0d exp 2/0", result, last_score);
        end
        checks++;
        if (saw_go !== 1'b0) begin errors++; $display("FAIL early_go got=%0d exp=0", saw_go); end
        checks++;
    endtask

    task automatic test_final_tick;
        int n;
        wait_state(3'd2, 20, n);
        wait_state(3'd3, 2100, n);
        react_after(9);
        if (result !== 2'd1 || last_score !== 9'd1 || total_score !== 11'd1) begin
            errors++; $display("FAIL final_tick result=%0d last=%0d total=%0d exp 1/1/1", result, last_score, total_score);
        end
        checks++;
        wait_state(3'd5, 20, n);
        if (best_score !== 11'd14) begin errors++; $display("FAIL best_game3 got=%0d exp=14", best_score); end
        checks++;
    endtask

    task automatic test_enable_drop;
        int n;
        // zero seed is forced to 1: 1 -> 2 -> 4, hold-off 9 ticks
        start_game(9'h000);
        wait_state(3'd2, 100, n);
        wait_state(3'd3, 2100, n);
        if (n !== 36) begin errors++; $display("FAIL wait_len_zero_seed got=%0d exp=36", n); end
        checks++;
        react_after(3);
        if (total_score !== 11'd7) begin errors++; $display("FAIL pre_drop_total got=%0d exp=7", total_score); end
        checks++;
        wait_state(3'd2, 20, n);
        wait_state(3'd3, 2100, n);
        step;
        step;
        enable = 1'b0;
        step;
        if (state !== 3'd0 || go !== 1'b0) begin
            errors++; $display("FAIL drop_state state=%0d go=%0d exp 0/0", state, go);
        end
        checks++;
        if (total_score !== 11'd0 || round_idx !== 2'd0 || result !== 2'd0) begin
            errors++; $display("FAIL drop_clear total=%0d round=%0d result=%0d exp 0/0/0", total_score, round_idx, result);
        end
        checks++;
        if (best_score !== 11'd14) begin errors++; $display("FAIL drop_best got=%0d exp=14", best_score); end
        checks++;
        enable = 1'b1;
        step;
    endtask

    task automatic test_reset_best;
        rst = 1'b1;
        step;
        if (best_score !== 11'd0 || state !== 3'd0) begin
            errors++; $display("FAIL rst_best best=%0d state=%0d exp 0/0", best_score, state);
        end
        checks++;
        rst = 1'b0;
        step;
    endtask

    initial begin
        test_reset;
        test_hit_game;
        test_seed_low;
        test_miss;
        test_early;
        test_final_tick;
        test_enable_drop;
        test_reset_best;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
